// File: rtl/riscv_fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory port plus decode-side handshake.
// master = fetch stage, slave = memory/decode/branch environment.
interface riscv_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc, id_ready,
        output if_valid, if_instr, if_pc, if_opcode,
        output misalign_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc, id_ready,
        input  if_valid, if_instr, if_pc, if_opcode,
        input  misalign_err
    );
endinterface

// File: rtl/riscv_fetch_stage.sv
// RISC-V instruction fetch stage: one outstanding imem request, redirect drop.
// Optional FETCH_PERF_CNT_EN adds a fetch_count handshake counter output.
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    riscv_fetch_stage_if.master    bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        drop;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] ipc_q;
    logic        misalign_q;
    logic [31:0] redir_pc;

    assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a response that must be dropped sends us back to REQ
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (bus.imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (drop || bus.redirect) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect || bus.id_ready) begin
                    state_nxt = REQ;
                end
            end
        endcase
    end

    // Memory request outputs: only REQ issues, so at most one is outstanding
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc;
        if (state == REQ) begin
            bus.imem_req = 1'b1;
        end
    end

    // PC, drop flag, decode-side registers and misalignment pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= RESET_VECTOR;
            drop       <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            ipc_q      <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bus.redirect & (|bus.redirect_pc[1:0]);
            unique case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        pc <= redir_pc;
                    end
                end
                REQ: begin
                    if (bus.redirect) begin
                        pc <= redir_pc;
                        if (bus.imem_gnt) begin
                            drop <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.redirect) begin
                        pc <= redir_pc;
                    end
                    if (bus.imem_rvalid) begin
                        drop <= 1'b0;
                        if (!drop && !bus.redirect) begin
                            valid_q <= 1'b1;
                            instr_q <= bus.imem_rdata;
                            ipc_q   <= pc;
                        end
                    end else if (bus.redirect) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        pc      <= redir_pc;
                        valid_q <= 1'b0;
                    end else if (bus.id_ready) begin
                        pc      <= pc + 32'd4;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Decode-side outputs
    always_comb begin
        bus.if_valid     = valid_q;
        bus.if_instr     = instr_q;
        bus.if_pc        = ipc_q;
        bus.if_opcode    = instr_q[6:0];
        bus.misalign_err = misalign_q;
    end

`ifdef FETCH_PERF_CNT_EN
    // Count instructions handed to decode
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_count <= 32'd0;
        end else if (state == HOLD && valid_q && bus.id_ready && !bus.redirect) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Scoreboard bench for riscv_fetch_stage: grant-address and instruction queues.
// Memory model answers one cycle after grant; can be muted or inject a stray beat.
module tb_riscv_fetch_stage;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic mute;
    logic stray;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_if_q[$];

    riscv_fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    riscv_fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: memf = 32'h0010_0093;
            32'h0000_0004: memf = 32'h0020_0113;
            32'h0000_0008: memf = 32'h0050_0093;
            32'h0000_000C: memf = 32'hDEAD_BEEF;
            32'h0000_0040: memf = 32'h02A0_0293;
            32'h0000_0100: memf = 32'h0000_0517;
            32'h0000_0200: memf = 32'h0000_006F;
            32'hFFFF_FFFC: memf = 32'h0000_8067;
            default:       memf = 32'hBAD0_0013;
        endcase
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, req);
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid_pc(input logic [31:0] p);
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (bus.if_valid && bus.if_pc == p) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_valid_pc actual timeout required pc %h", p);
        end
    endtask

    task automatic wait_grant();
        bit found;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_gnt) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_grant actual timeout required grant");
        end
        @(posedge clk);
        #2;
    endtask

    // Memory model: single-cycle read latency after grant
    initial begin
        logic        g;
        logic [31:0] a;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            g = bus.imem_req && bus.imem_gnt && !mute;
            a = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rvalid = g || stray;
            bus.imem_rdata  = g ? memf(a) : (stray ? 32'hBADB_AD13 : 32'h0);
            stray = 1'b0;
        end
    end

    // Monitor: grants and new if_valid presentations against the queues
    initial begin
        logic        prev_valid;
        logic [31:0] ea;
        logic [63:0] ei;
        logic [31:0] ei_instr;
        logic [31:0] op;
        logic [31:0] eop;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && bus.imem_req && bus.imem_gnt) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_addr actual %h required none",
                             bus.imem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk("grant_addr", bus.imem_addr, ea);
                end
            end
            if (bus.if_valid && !prev_valid) begin
                if (exp_if_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL if_out actual pc %h instr %h required none",
                             bus.if_pc, bus.if_instr);
                end else begin
                    ei = exp_if_q.pop_front();
                    ei_instr = ei[31:0];
                    op  = {25'd0, bus.if_opcode};
                    eop = {25'd0, ei_instr[6:0]};
                    chk("if_pc", bus.if_pc, ei[63:32]);
                    chk("if_instr", bus.if_instr, ei_instr);
                    chk("if_opcode", op, eop);
                end
            end
            prev_valid = bus.if_valid;
        end
    end

    initial begin
        checks          = 0;
        errors          = 0;
        mute            = 1'b0;
        stray           = 1'b0;
        reset_n         = 1'b0;
        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.id_ready    = 1'b1;
        cyc(3);
        chk("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'h0000_0013);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign_err}, 32'd0);

        // Sequential fetch 0,4,8
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_if_q.push_back({32'h0, 32'h0010_0093});
        exp_if_q.push_back({32'h4, 32'h0020_0113});
        exp_if_q.push_back({32'h8, 32'h0050_0093});
        reset_n = 1'b1;
        wait_valid_pc(32'h8);
        bus.id_ready = 1'b0;

        // Decode stall: held output, no request
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("hold_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("hold_instr", bus.if_instr, 32'h0050_0093);
            chk("hold_pc", bus.if_pc, 32'h8);
            chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        end

        // Redirect in WAIT drops 0xDEADBEEF
        exp_addr_q.push_back(32'hC);
        bus.id_ready = 1'b1;
        cyc(1);
        bus.id_ready = 1'b0;
        wait_grant();
        exp_addr_q.push_back(32'h100);
        exp_if_q.push_back({32'h100, 32'h0000_0517});
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        cyc(1);
        bus.redirect = 1'b0;
        chk("drop_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("drop_addr", bus.imem_addr, 32'h100);
        wait_valid_pc(32'h100);

        // Misaligned redirect in HOLD
        chk("pre_misalign", {31'd0, bus.misalign_err}, 32'd0);
        exp_addr_q.push_back(32'h200);
        exp_if_q.push_back({32'h200, 32'h0000_006F});
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h202;
        cyc(1);
        bus.redirect = 1'b0;
        chk("misalign_pulse", {31'd0, bus.misalign_err}, 32'd1);
        chk("redir_hold_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("misalign_addr", bus.imem_addr, 32'h200);
        cyc(1);
        chk("misalign_end", {31'd0, bus.misalign_err}, 32'd0);
        wait_valid_pc(32'h200);

        // PC wrap from 0xFFFFFFFC
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_if_q.push_back({32'hFFFF_FFFC, 32'h0000_8067});
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        cyc(1);
        bus.redirect = 1'b0;
        wait_valid_pc(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0);
        exp_if_q.push_back({32'h0, 32'h0010_0093});
        bus.id_ready = 1'b1;
        cyc(1);
        bus.id_ready = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_valid", {31'd0, bus.if_valid}, 32'd0);
        wait_valid_pc(32'h0);

        // Redirect in REQ: ungranted then granted same cycle
        bus.imem_gnt = 1'b0;
        bus.id_ready = 1'b1;
        cyc(1);
        bus.id_ready = 1'b0;
        chk("req_stall_req", {31'd0, bus.imem_req}, 32'd1);
        chk("req_stall_addr", bus.imem_addr, 32'h4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        cyc(1);
        bus.redirect = 1'b0;
        chk("req_redir_addr", bus.imem_addr, 32'h80);
        exp_addr_q.push_back(32'h80);
        exp_addr_q.push_back(32'h40);
        exp_if_q.push_back({32'h40, 32'h02A0_0293});
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        bus.imem_gnt    = 1'b1;
        cyc(1);
        bus.redirect = 1'b0;
        cyc(1);
        chk("gnt_drop_valid", {31'd0, bus.if_valid}, 32'd0);
        wait_valid_pc(32'h40);

        // Reset during WAIT, stray rvalid afterwards
        mute = 1'b1;
        exp_addr_q.push_back(32'h44);
        bus.id_ready = 1'b1;
        cyc(1);
        bus.id_ready = 1'b0;
        cyc(2);
        reset_n      = 1'b0;
        bus.imem_gnt = 1'b0;
        cyc(1);
        chk("mid_rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("mid_rst_instr", bus.if_instr, 32'h0000_0013);
        chk("mid_rst_pc", bus.if_pc, 32'h0);
        chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        cyc(1);
        reset_n = 1'b1;
        stray   = 1'b1;
        mute    = 1'b0;
        cyc(3);
        chk("stray_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("stray_instr", bus.if_instr, 32'h0000_0013);
        chk("stray_req", {31'd0, bus.imem_req}, 32'd1);
        chk("stray_addr", bus.imem_addr, 32'h0);
        exp_addr_q.push_back(32'h0);
        exp_if_q.push_back({32'h0, 32'h0010_0093});
        bus.imem_gnt = 1'b1;
        wait_valid_pc(32'h0);

        // Drain: every expectation consumed
        for (int i = 0; i < 20; i++) begin
            if (exp_addr_q.size() == 0 && exp_if_q.size() == 0) break;
            cyc(1);
        end
        chk("addr_q_left", exp_addr_q.size(), 32'd0);
        chk("if_q_left", exp_if_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_stage.md
RISCV_FETCH_STAGE -- requirements
Module: riscv_fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: imem_req  output  1  instruction-memory read request, held until accepted.
REQ-005 SHALL have port: imem_addr  output  32  word-aligned fetch address (bits[1:0]=0).
REQ-006 SHALL have port: imem_gnt  input  1  request accepted in the cycle where imem_req=1 and imem_gnt=1.
REQ-007 SHALL have port: imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
REQ-008 SHALL have port: imem_rdata  input  32  instruction word.
REQ-009 SHALL have port: redirect  input  1  branch/jump taken; overrides sequential PC.
REQ-010 SHALL have port: redirect_pc  input  32  redirect target.
REQ-011 SHALL have port: id_ready  input  1  decode stage accepts the instruction.
REQ-012 SHALL have port: if_valid  output  1  if_instr/if_pc/if_opcode are valid.
REQ-013 SHALL have port: if_instr  output  32  fetched instruction.
REQ-014 SHALL have port: if_pc  output  32  address of if_instr.
REQ-015 SHALL have port: if_opcode  output  7  if_instr[6:0]; drives the control unit opcode input.
REQ-016 SHALL have port: misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, HOLD.
REQ-018 IDLE SHALL go to REQ on the next cycle; imem_req=0 in IDLE.
REQ-019 REQ SHALL assert imem_req=1, imem_addr=pc, and go to WAIT on grant; otherwise stay in REQ.
REQ-020 WAIT SHALL capture imem_rdata into if_instr and pc into if_pc on imem_rvalid, set if_valid=1, and go to HOLD.
REQ-021 HOLD SHALL keep if_valid/if_instr/if_pc stable while id_ready=0.
REQ-022 HOLD with id_ready=1 SHALL set pc=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), clear if_valid next cycle, and go to REQ.
REQ-023 Only one request SHALL be outstanding; imem_req SHALL be 0 in WAIT and HOLD.
REQ-024 Redirect in REQ SHALL update pc=redirect_pc & ~3 that cycle; imem_addr changes only if not granted in that cycle; a granted old address is handled per REQ-025.
REQ-025 Redirect in WAIT (or granted in the same cycle) SHALL set a drop flag; the returning response SHALL be discarded (if_valid stays 0), then fetch resumes in REQ at the new pc.
REQ-026 Redirect in HOLD SHALL clear if_valid next cycle regardless of id_ready, load pc=redirect_pc & ~3, and go to REQ.
REQ-027 Redirect SHALL take priority over id_ready and over sequential increment.
REQ-028 misalign_err SHALL pulse for exactly one cycle after any cycle with redirect=1 and redirect_pc[1:0]!=0.
REQ-029 Fetch-to-if_valid latency SHALL be: grant cycle + memory latency + 1 register cycle.
REQ-030 if_opcode SHALL always equal if_instr[6:0], combinationally.

Reset
REQ-031 When reset_n=0 at a clock edge, outputs SHALL be: pc=RESET_VECTOR, state=IDLE, imem_req=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_VECTOR, misalign_err=0, drop flag=0.
REQ-032 Reset asserted mid-request SHALL abandon the request; the first imem_rvalid after reset without a new grant SHALL be ignored.

Configuration
REQ-033 With FETCH_PERF_CNT_EN defined, SHALL add output fetch_count (32 bits): reset to 0, +1 per HOLD handshake (if_valid & id_ready & ~redirect), wraps at 2^32.
REQ-034 Without FETCH_PERF_CNT_EN, SHALL omit fetch_count and its logic entirely; all other behaviour is identical.

Verification
REQ-035 Reset release, 1-cycle memory, id_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_pc follows; if_opcode = rdata[6:0].
REQ-036 id_ready=0 for 5 cycles with rdata 0x00500093 -> if_instr held at 0x00500093, imem_req=0 throughout, no PC advance.
REQ-037 redirect=1 to 0x100 while in WAIT, memory returns 0xDEADBEEF -> data dropped, if_valid stays 0, next imem_addr=0x100.
REQ-038 redirect_pc=0x202 -> misalign_err single-cycle pulse, next imem_addr=0x200.
REQ-039 redirect to 0xFFFFFFFC, then id_ready=1 -> next imem_addr=0x0.
REQ-040 reset_n=0 during WAIT, stray imem_rvalid=1 after release -> ignored; outputs equal REQ-031 values; fetch restarts at RESET_VECTOR.
